// File: rtl/cpu_pkg.sv
// Shared constants for the bus-based CPU datapath slice: data width,
// ALU opcodes and bus-source encoder codes.
package cpu_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0]   word_t;
  typedef logic [2*DATA_W-1:0] dword_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;

  localparam logic [4:0] SRC_R3   = 5'd3;
  localparam logic [4:0] SRC_R5   = 5'd5;
  localparam logic [4:0] SRC_Z_HI = 5'd18;
  localparam logic [4:0] SRC_Z_LO = 5'd19;
  localparam logic [4:0] SRC_PC   = 5'd20;
  localparam logic [4:0] SRC_MDR  = 5'd21;
  localparam logic [4:0] SRC_NONE = 5'd31;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: operand A from Y, operand B from the bus, 64-bit result
// destined for Z. inc_i overrides the opcode for the PC increment path.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  input  logic [4:0]          opcode_i,
  input  logic                inc_i,
  output logic [2*DATA_W-1:0] result_o
);

  logic [4:0]               shamt;
  logic [5:0]               shamt_inv;
  dword_t                   product;
  logic signed [DATA_W-1:0] quot;
  logic signed [DATA_W-1:0] rem;
  word_t                    lo;

  assign shamt     = b_i[4:0];
  assign shamt_inv = 6'd32 - {1'b0, shamt};
  assign product   = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i}) *
                     $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});

  // Divide by zero yields Z=0 rather than an undefined quotient.
  always_comb begin
    quot = '0;
    rem  = '0;
    if (b_i != '0) begin
      quot = $signed(a_i) / $signed(b_i);
      rem  = $signed(a_i) % $signed(b_i);
    end
  end

  always_comb begin
    lo = '0;
    case (opcode_i)
      OP_ADD:  lo = a_i + b_i;
      OP_SUB:  lo = a_i - b_i;
      OP_AND:  lo = a_i & b_i;
      OP_OR:   lo = a_i | b_i;
      OP_SHR:  lo = a_i >> shamt;
      OP_SHRA: lo = $unsigned($signed(a_i) >>> shamt);
      OP_SHL:  lo = a_i << shamt;
      OP_ROR:  lo = (a_i >> shamt) | (a_i << shamt_inv);
      OP_ROL:  lo = (a_i << shamt) | (a_i >> shamt_inv);
      OP_NEG:  lo = -b_i;
      OP_NOT:  lo = ~b_i;
      default: lo = '0;
    endcase
  end

  always_comb begin
    if (inc_i)                  result_o = {{DATA_W{1'b0}}, b_i + word_t'(1)};
    else if (opcode_i == OP_MUL) result_o = product;
    else if (opcode_i == OP_DIV) result_o = {rem, quot};
    else                         result_o = {{DATA_W{1'b0}}, lo};
  end

endmodule

// File: rtl/cpu_datapath.sv
// 32-bit bus-based datapath slice: register file, one-hot source encoder,
// shared bus, MDR input mux and the ALU feeding the 64-bit Z register.
module cpu_datapath
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r1_enable,
  input  logic              r3_enable,
  input  logic              r5_enable,
  input  logic              PC_enable,
  input  logic              PC_increment_enable,
  input  logic              IR_enable,
  input  logic              Y_enable,
  input  logic              MAR_enable,
  input  logic              Z_enable,
  input  logic              MDR_enable,
  input  logic              read,
  input  logic              r3_select,
  input  logic              r5_select,
  input  logic              PC_select,
  input  logic              Z_HI_select,
  input  logic              Z_LO_select,
  input  logic              MDR_select,
  output logic [4:0]        encode_sel_signal,
  input  logic [4:0]        alu_instruction,
  input  logic [DATA_W-1:0] MDataIN,
  output logic [DATA_W-1:0] bus_Data,
  output logic [2*DATA_W-1:0] aluResult,
  output logic [DATA_W-1:0] R1_Data,
  output logic [DATA_W-1:0] R3_Data,
  output logic [DATA_W-1:0] R5_Data,
  output logic [DATA_W-1:0] PC_Data,
  output logic [DATA_W-1:0] IR_Data,
  output logic [DATA_W-1:0] Y_Data,
  output logic [DATA_W-1:0] Z_HI_Data,
  output logic [DATA_W-1:0] Z_LO_Data,
  output logic [DATA_W-1:0] MAR_Data,
  output logic [DATA_W-1:0] MDR_Data
);

  word_t  r1_q, r3_q, r5_q, pc_q, ir_q, y_q, mar_q, mdr_q;
  word_t  mdr_d;
  dword_t z_q;
  logic [4:0] enc;
  word_t  bus;

  // Highest code wins when several selects are asserted together.
  always_comb begin
    enc = SRC_NONE;
    if      (MDR_select)  enc = SRC_MDR;
    else if (PC_select)   enc = SRC_PC;
    else if (Z_LO_select) enc = SRC_Z_LO;
    else if (Z_HI_select) enc = SRC_Z_HI;
    else if (r5_select)   enc = SRC_R5;
    else if (r3_select)   enc = SRC_R3;
  end

  always_comb begin
    case (enc)
      SRC_R3:   bus = r3_q;
      SRC_R5:   bus = r5_q;
      SRC_Z_HI: bus = z_q[2*DATA_W-1:DATA_W];
      SRC_Z_LO: bus = z_q[DATA_W-1:0];
      SRC_PC:   bus = pc_q;
      SRC_MDR:  bus = mdr_q;
      default:  bus = '0;
    endcase
  end

  assign mdr_d = read ? MDataIN : bus;

  cpu_alu u_alu (
    .a_i      (y_q),
    .b_i      (bus),
    .opcode_i (alu_instruction),
    .inc_i    (PC_increment_enable),
    .result_o (aluResult)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_q  <= '0;
      r3_q  <= '0;
      r5_q  <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      y_q   <= '0;
      z_q   <= '0;
      mar_q <= '0;
      mdr_q <= '0;
    end else begin
      if (r1_enable)  r1_q  <= bus;
      if (r3_enable)  r3_q  <= bus;
      if (r5_enable)  r5_q  <= bus;
      if (PC_enable)  pc_q  <= bus;
      if (IR_enable)  ir_q  <= bus;
      if (Y_enable)   y_q   <= bus;
      if (MAR_enable) mar_q <= bus;
      if (Z_enable)   z_q   <= aluResult;
      if (MDR_enable) mdr_q <= mdr_d;
    end
  end

  assign encode_sel_signal = enc;
  assign bus_Data  = bus;
  assign R1_Data   = r1_q;
  assign R3_Data   = r3_q;
  assign R5_Data   = r5_q;
  assign PC_Data   = pc_q;
  assign IR_Data   = ir_q;
  assign Y_Data    = y_q;
  assign Z_HI_Data = z_q[2*DATA_W-1:DATA_W];
  assign Z_LO_Data = z_q[DATA_W-1:0];
  assign MAR_Data  = mar_q;
  assign MDR_Data  = mdr_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: control steps are applied one clock at a
// time and results compared against hand-computed values.
module tb_cpu_datapath;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r1_enable, r3_enable, r5_enable, PC_enable, PC_increment_enable;
  logic        IR_enable, Y_enable, MAR_enable, Z_enable, MDR_enable, read;
  logic        r3_select, r5_select, PC_select, Z_HI_select, Z_LO_select, MDR_select;
  logic [4:0]  encode_sel_signal;
  logic [4:0]  alu_instruction;
  logic [31:0] MDataIN;
  logic [31:0] bus_Data;
  logic [63:0] aluResult;
  logic [31:0] R1_Data, R3_Data, R5_Data, PC_Data, IR_Data, Y_Data;
  logic [31:0] Z_HI_Data, Z_LO_Data, MAR_Data, MDR_Data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_datapath dut (
    .clk(clk), .rst_n(rst_n),
    .r1_enable(r1_enable), .r3_enable(r3_enable), .r5_enable(r5_enable),
    .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable),
    .IR_enable(IR_enable), .Y_enable(Y_enable), .MAR_enable(MAR_enable),
    .Z_enable(Z_enable), .MDR_enable(MDR_enable), .read(read),
    .r3_select(r3_select), .r5_select(r5_select), .PC_select(PC_select),
    .Z_HI_select(Z_HI_select), .Z_LO_select(Z_LO_select), .MDR_select(MDR_select),
    .encode_sel_signal(encode_sel_signal), .alu_instruction(alu_instruction),
    .MDataIN(MDataIN), .bus_Data(bus_Data), .aluResult(aluResult),
    .R1_Data(R1_Data), .R3_Data(R3_Data), .R5_Data(R5_Data), .PC_Data(PC_Data),
    .IR_Data(IR_Data), .Y_Data(Y_Data), .Z_HI_Data(Z_HI_Data), .Z_LO_Data(Z_LO_Data),
    .MAR_Data(MAR_Data), .MDR_Data(MDR_Data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_ctrl();
    r1_enable = 0; r3_enable = 0; r5_enable = 0; PC_enable = 0;
    PC_increment_enable = 0; IR_enable = 0; Y_enable = 0; MAR_enable = 0;
    Z_enable = 0; MDR_enable = 0; read = 0;
    r3_select = 0; r5_select = 0; PC_select = 0; Z_HI_select = 0;
    Z_LO_select = 0; MDR_select = 0; alu_instruction = 5'b00000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    clear_ctrl();
    MDataIN = v; read = 1; MDR_enable = 1;
    tick();
    clear_ctrl();
  endtask

  task automatic mdr_to_y();
    clear_ctrl();
    MDR_select = 1; Y_enable = 1;
    tick();
    clear_ctrl();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " R1"}, {32'h0, R1_Data}, 64'h0);
    chk({tag, " R3"}, {32'h0, R3_Data}, 64'h0);
    chk({tag, " R5"}, {32'h0, R5_Data}, 64'h0);
    chk({tag, " PC"}, {32'h0, PC_Data}, 64'h0);
    chk({tag, " IR"}, {32'h0, IR_Data}, 64'h0);
    chk({tag, " Y"}, {32'h0, Y_Data}, 64'h0);
    chk({tag, " ZHI"}, {32'h0, Z_HI_Data}, 64'h0);
    chk({tag, " ZLO"}, {32'h0, Z_LO_Data}, 64'h0);
    chk({tag, " MAR"}, {32'h0, MAR_Data}, 64'h0);
    chk({tag, " MDR"}, {32'h0, MDR_Data}, 64'h0);
    chk({tag, " bus"}, {32'h0, bus_Data}, 64'h0);
    chk({tag, " enc"}, {59'h0, encode_sel_signal}, 64'd31);
  endtask

  initial begin
    clear_ctrl();
    MDataIN = 32'h0;
    rst_n = 0;
    #3;
    chk_all_zero("reset");
    #10 rst_n = 1;
    tick();

    // Register loads through MDR
    load_mdr(32'h12);
    chk("mdr_load", {32'h0, MDR_Data}, 64'h12);
    MDR_select = 1; r3_enable = 1; #1;
    chk("enc_mdr", {59'h0, encode_sel_signal}, 64'd21);
    chk("bus_mdr", {32'h0, bus_Data}, 64'h12);
    tick();
    chk("r3_load", {32'h0, R3_Data}, 64'h12);
    load_mdr(32'h14);
    MDR_select = 1; r5_enable = 1; tick();
    chk("r5_load", {32'h0, R5_Data}, 64'h14);
    load_mdr(32'h18);
    MDR_select = 1; r1_enable = 1; tick();
    chk("r1_load", {32'h0, R1_Data}, 64'h18);
    chk("r3_hold", {32'h0, R3_Data}, 64'h12);

    // Fetch
    clear_ctrl();
    PC_select = 1; MAR_enable = 1; PC_increment_enable = 1; Z_enable = 1;
    alu_instruction = OP_SUB; #1;
    chk("enc_pc", {59'h0, encode_sel_signal}, 64'd20);
    chk("inc_alu", aluResult, 64'h1);
    tick();
    chk("fetch_mar", {32'h0, MAR_Data}, 64'h0);
    chk("fetch_zlo", {32'h0, Z_LO_Data}, 64'h1);
    clear_ctrl();
    Z_LO_select = 1; PC_enable = 1; read = 1; MDR_enable = 1; MDataIN = 32'h409A8000;
    tick();
    chk("fetch_pc", {32'h0, PC_Data}, 64'h1);
    chk("fetch_mdr", {32'h0, MDR_Data}, 64'h409A8000);
    clear_ctrl();
    MDR_select = 1; IR_enable = 1; tick();
    chk("fetch_ir", {32'h0, IR_Data}, 64'h409A8000);

    // SHRA R1,R3,R5
    clear_ctrl();
    r3_select = 1; Y_enable = 1; tick();
    chk("shra_y", {32'h0, Y_Data}, 64'h12);
    clear_ctrl();
    r5_select = 1; alu_instruction = OP_SHRA; Z_enable = 1; #1;
    chk("enc_r5", {59'h0, encode_sel_signal}, 64'd5);
    tick();
    chk("shra_z", {Z_HI_Data, Z_LO_Data}, 64'h0);
    clear_ctrl();
    Z_LO_select = 1; r1_enable = 1; tick();
    chk("shra_r1", {32'h0, R1_Data}, 64'h0);

    // Shifts and logic with A=0x80000000, B=4
    load_mdr(32'h80000000);
    mdr_to_y();
    load_mdr(32'h4);
    MDR_select = 1;
    alu_instruction = OP_SHRA; #1; chk("alu_shra", aluResult, 64'h00000000_F8000000);
    alu_instruction = OP_SHR;  #1; chk("alu_shr",  aluResult, 64'h00000000_08000000);
    alu_instruction = OP_SHL;  #1; chk("alu_shl",  aluResult, 64'h0);
    alu_instruction = OP_ROR;  #1; chk("alu_ror",  aluResult, 64'h00000000_08000000);
    alu_instruction = OP_ROL;  #1; chk("alu_rol",  aluResult, 64'h00000000_00000008);
    alu_instruction = OP_ADD;  #1; chk("alu_add",  aluResult, 64'h00000000_80000004);
    alu_instruction = OP_SUB;  #1; chk("alu_sub",  aluResult, 64'h00000000_7FFFFFFC);
    alu_instruction = OP_AND;  #1; chk("alu_and",  aluResult, 64'h0);
    alu_instruction = OP_OR;   #1; chk("alu_or",   aluResult, 64'h00000000_80000004);
    alu_instruction = OP_NEG;  #1; chk("alu_neg",  aluResult, 64'h00000000_FFFFFFFC);
    alu_instruction = OP_NOT;  #1; chk("alu_not",  aluResult, 64'h00000000_FFFFFFFB);
    alu_instruction = 5'b01100; #1; chk("alu_undef", aluResult, 64'h0);
    alu_instruction = OP_ADD; PC_increment_enable = 1; #1;
    chk("inc_override", aluResult, 64'h5);
    PC_increment_enable = 0;
    alu_instruction = OP_SHRA; Z_enable = 1; tick();
    chk("shra_zlo", {32'h0, Z_LO_Data}, 64'hF8000000);
    chk("shra_zhi", {32'h0, Z_HI_Data}, 64'h0);

    // Encoder priority
    clear_ctrl();
    MDR_select = 1; r3_select = 1; #1;
    chk("prio_mdr_r3", {59'h0, encode_sel_signal}, 64'd21);
    clear_ctrl();
    PC_select = 1; Z_HI_select = 1; r5_select = 1; #1;
    chk("prio_pc_zhi", {59'h0, encode_sel_signal}, 64'd20);
    clear_ctrl();
    Z_HI_select = 1; r3_select = 1; #1;
    chk("prio_zhi_r3", {59'h0, encode_sel_signal}, 64'd18);

    // MUL / DIV
    load_mdr(32'hFFFFFFFD);
    mdr_to_y();
    load_mdr(32'h7);
    MDR_select = 1; alu_instruction = OP_MUL; Z_enable = 1; #1;
    chk("mul_alu", aluResult, 64'hFFFFFFFF_FFFFFFEB);
    tick();
    chk("mul_z", {Z_HI_Data, Z_LO_Data}, 64'hFFFFFFFF_FFFFFFEB);
    clear_ctrl();
    Z_HI_select = 1; #1;
    chk("bus_zhi", {32'h0, bus_Data}, 64'hFFFFFFFF);

    // Z sources the bus while PC loads and Z updates in the same cycle
    clear_ctrl();
    Z_LO_select = 1; PC_enable = 1; PC_increment_enable = 1; Z_enable = 1;
    tick();
    chk("rmw_pc", {32'h0, PC_Data}, 64'hFFFFFFEB);
    chk("rmw_z", {Z_HI_Data, Z_LO_Data}, 64'h00000000_FFFFFFEC);

    load_mdr(32'd17);
    mdr_to_y();
    load_mdr(32'd5);
    MDR_select = 1; alu_instruction = OP_DIV; Z_enable = 1; tick();
    chk("div_z", {Z_HI_Data, Z_LO_Data}, 64'h00000002_00000003);
    load_mdr(32'd0);
    MDR_select = 1; alu_instruction = OP_DIV; Z_enable = 1; tick();
    chk("div0_z", {Z_HI_Data, Z_LO_Data}, 64'h0);

    // Increment wraps at 2^32
    load_mdr(32'hFFFFFFFF);
    MDR_select = 1; PC_increment_enable = 1; #1;
    chk("inc_wrap", aluResult, 64'h0);

    // Asynchronous reset between edges
    clear_ctrl();
    MDR_select = 1; r3_enable = 1; r5_enable = 1; PC_enable = 1; IR_enable = 1;
    Y_enable = 1; MAR_enable = 1; tick();
    chk("pre_rst_r3", {32'h0, R3_Data}, 64'hFFFFFFFF);
    clear_ctrl();
    #2 rst_n = 0;
    #1;
    chk_all_zero("async_rst");
    #2 rst_n = 1;
    tick();
    chk("post_rst_mdr", {32'h0, MDR_Data}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Bus-based 32-bit CPU datapath slice: registers R1/R3/R5, PC, IR, Y, 64-bit Z (HI/LO), MAR and MDR around one shared combinational bus.
- Bus sources are chosen by one-hot select inputs through a 32-to-5 encoder.
- A combinational ALU computes from Y (operand A) and the bus (operand B) into Z.
- Control signals come from an external control unit (or a bench) one step at a time; the block has no sequencer of its own.

Parameters:
- DATA_W, 32, register and bus width; Z and aluResult are 2*DATA_W wide.

Ports:
- clk  in  1  system clock; all registers load on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- r1_enable, r3_enable, r5_enable  in  1 each  load the bus into R1/R3/R5.
- PC_enable  in  1  load the bus into PC.
- PC_increment_enable  in  1  force the ALU to compute bus+1.
- IR_enable, Y_enable, MAR_enable  in  1 each  load the bus into IR/Y/MAR.
- Z_enable  in  1  load aluResult into Z.
- MDR_enable  in  1  load the MDR input-mux output into MDR.
- read  in  1  MDR mux select: 1 = MDataIN, 0 = bus.
- r3_select, r5_select, PC_select, Z_HI_select, Z_LO_select, MDR_select  in  1 each  one-hot bus source selects.
- encode_sel_signal  out  5  encoded bus source.
- alu_instruction  in  5  ALU opcode.
- MDataIN  in  32  memory read data.
- bus_Data  out  32  current bus value.
- aluResult  out  64  combinational ALU output.
- R1_Data, R3_Data, R5_Data, PC_Data, IR_Data, Y_Data, Z_HI_Data, Z_LO_Data, MAR_Data, MDR_Data  out  32 each  register contents.

Behaviour:
- Reset: asserting rst_n=0 immediately clears every register (R1, R3, R5, PC, IR, Y, Z, MAR, MDR) to 0; no clock is needed.
- Register loads: a register loads on posedge clk only when its enable is 1, otherwise it holds. Multiple enables in the same cycle all load the same bus value.
- Encoder codes: R3=3, R5=5, Z_HI=18, Z_LO=19, PC=20, MDR=21.
  - If several selects are high, the highest code wins.
  - If no select is high, the code is 31.
- Bus (combinational) by encoder code: 3→R3, 5→R5, 18→Z[63:32], 19→Z[31:0], 20→PC, 21→MDR, 31→0.
- MDR input: read ? MDataIN : bus_Data.
- ALU override: when PC_increment_enable=1, aluResult = {32'b0, bus+1} (wraps at 2^32); alu_instruction is ignored.
- ALU operations (A=Y, B=bus, shift amount = B[4:0]):
  - 00011 ADD, 00100 SUB, 00101 AND, 00110 OR.
  - 00111 SHR logical, 01000 SHRA arithmetic (sign-filling), 01001 SHL, 01010 ROR, 01011 ROL.
  - 01110 MUL: signed 64-bit product A*B.
  - 01111 DIV (signed): HI=remainder, LO=quotient; B=0 gives Z=0.
  - 10000 NEG: -B. 10001 NOT: ~B.
  - Any other opcode: 0.
- Result width: for all 32-bit results, HI=0 and LO=result.
- Latency: the bus, encoder and ALU are zero-latency combinational; every register update is 1 cycle.
- Read-modify-write: Z may source the bus in the same cycle PC loads from it; the old Z value is used.

Decomposition:
- Shared package (cpu_pkg) holds:
  - ALU opcode constants (OP_ADD … OP_NOT, OP_SHRA=5'b01000).
  - Encoder code constants (SRC_R3=3 … SRC_MDR=21, SRC_NONE=31).
  - DATA_W.
- One sub-module, cpu_alu: inputs A, B, opcode, inc; output 64-bit result.
- Register file, encoder, bus mux and MDR mux stay inline.

Test Plan:
1. Register load: MDataIN=0x12, read=1, MDR_enable=1 for one edge; then MDR_select=1, r3_enable=1 → R3=0x12, encode_sel_signal=21 while MDR drives the bus. Repeat with 0x14→R5 and 0x18→R1.
2. Fetch from PC=0:
   - PC_select, MAR_enable, PC_increment_enable, Z_enable → MAR=0, Z_LO=1.
   - Z_LO_select, PC_enable, read, MDR_enable with MDataIN=0x409A8000 → PC=1, MDR=0x409A8000.
   - MDR_select, IR_enable → IR=0x409A8000.
3. SHRA R1,R3,R5: r3_select+Y_enable → Y=0x12; r5_select, opcode 01000, Z_enable → Z=0; Z_LO_select+r1_enable → R1=0x00000000.
4. SHRA sign fill: Y=0x80000000, B=4 → Z_LO=0xF8000000, Z_HI=0. The same operands with SHR → 0x08000000.
5. MUL/DIV: Y=-3, B=7 MUL → Z=0xFFFFFFFF_FFFFFFEB. Y=17, B=5 DIV → HI=2, LO=3. B=0 DIV → Z=0.
6. Asynchronous reset: drop rst_n between clock edges mid-sequence → all *_Data outputs 0 immediately. With no selects, bus_Data=0 and encode_sel_signal=31.
